// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared processor package for the instruction prefetch path.
// Holds the fetch FSM state type and the default word/address widths
// used as parameter defaults by the prefetch buffer.
package instruction_prefetch_buffer_pkg;

    localparam int DEFAULT_WORD_SIZE     = 16;
    localparam int DEFAULT_ADDRESS_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Word FIFO behind the prefetch buffer.
// Ports:
//   clock, reset_n   - clock, async active-low reset
//   clear            - drop all contents (takes priority over push/pop)
//   push, push_data  - write one word at the tail
//   pop_count        - 0..2 words removed from the head (caller guarantees legality)
//   head_word        - word at head, 0 when empty
//   next_word        - word at head+1, 0 when fewer than two words
//   count            - number of words held
module prefetch_fifo #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic [1:0]           pop_count,
    output logic [WORD_SIZE-1:0] head_word,
    output logic [WORD_SIZE-1:0] next_word,
    output logic [CNT_W-1:0]     count
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [CNT_W-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            // Pointers are log2(DEPTH) wide, so the add wraps around the ring.
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_count);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop_count);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are gated by count.
    always_ff @(posedge clock) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_next   = rd_ptr_q + PTR_W'(1);
    assign head_word = (count_q != '0)          ? mem_q[rd_ptr_q] : '0;
    assign next_word = (count_q >  CNT_W'(1))   ? mem_q[rd_next]  : '0;
    assign count     = count_q;

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: streams words from a synchronous program RAM
// (one-cycle read latency) into a small FIFO, exposing head and head+1 words.
// Ports:
//   clock, reset_n          - clock, async active-low reset
//   enable                  - fetching permitted
//   flush, flush_address    - jump: discard contents, refetch from target
//   consume                 - words popped this cycle (0..2; 3 illegal)
//   p_ram_read/_address     - read request to program RAM
//   p_ram_data              - RAM data, one cycle after p_ram_read
//   instruction, peek       - head and head+1 words (0 when not valid)
//   instruction_valid/peek_valid - at least 1 / 2 words buffered
//   head_address            - program address of the head word
//   occupancy               - words buffered
//   underflow_error         - sticky, set by an over-consume
module instruction_prefetch_buffer
    import instruction_prefetch_buffer_pkg::*;
#(
    parameter int WORD_SIZE     = DEFAULT_WORD_SIZE,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DEPTH         = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] flush_address,
    input  logic [1:0]               consume,
    output logic                     p_ram_read,
    output logic [ADDRESS_WIDTH-1:0] p_ram_address,
    input  logic [WORD_SIZE-1:0]     p_ram_data,
    output logic [WORD_SIZE-1:0]     instruction,
    output logic [WORD_SIZE-1:0]     peek,
    output logic                     instruction_valid,
    output logic                     peek_valid,
    output logic [ADDRESS_WIDTH-1:0] head_address,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     underflow_error
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d, head_addr_q, head_addr_d;
    logic                     inflight_q, inflight_d, underflow_q, underflow_d;
    logic                     push, illegal, can_fetch;
    logic [1:0]               pop_count;
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           pending;

    // Reserve a slot for the word still in flight; a same-cycle pop earns no credit.
    assign pending   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign can_fetch = pending < DEPTH_LIM;
    assign illegal   = (consume == 2'd3) || (CNT_W'(consume) > count);

    always_comb begin
        state_d     = state_q;
        p_ram_read  = 1'b0;
        fetch_ptr_d = fetch_ptr_q;
        head_addr_d = head_addr_q;
        inflight_d  = 1'b0;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop_count   = 2'd0;
        if (flush) begin
            // Clearing inflight drops the word returning from the pre-flush read.
            state_d     = REDIRECT;
            fetch_ptr_d = flush_address;
            head_addr_d = flush_address;
        end else begin
            case (state_q)
                IDLE:     if (enable) state_d = STREAM;
                STREAM:   if (!enable) state_d = IDLE;
                REDIRECT: state_d = enable ? STREAM : IDLE;
                default:  state_d = IDLE;
            endcase
            p_ram_read = ((state_q == STREAM) || (state_q == REDIRECT)) && enable && can_fetch;
            inflight_d = p_ram_read;
            if (p_ram_read) fetch_ptr_d = fetch_ptr_q + ADDRESS_WIDTH'(1);
            push = inflight_q;
            if (illegal) underflow_d = 1'b1;
            else         pop_count   = consume;
            head_addr_d = head_addr_q + ADDRESS_WIDTH'(pop_count);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fetch_ptr_q <= '0;
            head_addr_q <= '0;
            inflight_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            head_addr_q <= head_addr_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
        end
    end

    prefetch_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (push),
        .push_data (p_ram_data),
        .pop_count (pop_count),
        .head_word (instruction),
        .next_word (peek),
        .count     (count)
    );

    assign p_ram_address     = fetch_ptr_q;
    assign head_address      = head_addr_q;
    assign occupancy         = count;
    assign instruction_valid = (count != '0);
    assign peek_valid        = (count > CNT_W'(1));
    assign underflow_error   = underflow_q;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
module tb_instruction_prefetch_buffer;

    logic        clock = 1'b0;
    logic        reset_n, enable, flush;
    logic [15:0] flush_address;
    logic [1:0]  consume;
    logic        p_ram_read;
    logic [15:0] p_ram_address;
    logic [15:0] p_ram_data = 16'h0;
    logic [15:0] instruction, peek, head_address;
    logic        instruction_valid, peek_valid, underflow_error;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    int rd_seen;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    instruction_prefetch_buffer #(
        .WORD_SIZE(16), .ADDRESS_WIDTH(16), .DEPTH(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush),
        .flush_address(flush_address), .consume(consume),
        .p_ram_read(p_ram_read), .p_ram_address(p_ram_address), .p_ram_data(p_ram_data),
        .instruction(instruction), .peek(peek),
        .instruction_valid(instruction_valid), .peek_valid(peek_valid),
        .head_address(head_address), .occupancy(occupancy),
        .underflow_error(underflow_error)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] ram_word(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h1100;
            16'd1:   return 16'h2205;
            16'd2:   return 16'h3300;
            16'd3:   return 16'h4400;
            default: return {a[7:0] ^ 8'h5A, a[7:0]};
        endcase
    endfunction

    // Synchronous program RAM, one-cycle latency.
    always @(posedge clock) if (p_ram_read) p_ram_data <= ram_word(p_ram_address);

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_stream(input logic [15:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            e.addr = start + 16'(i);
            e.data = ram_word(e.addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_head(input string tag);
        chk({tag, "_instr"}, instruction, exp_q[0].data);
        chk({tag, "_haddr"}, head_address, exp_q[0].addr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_occ"}, occupancy, 0);
        chk({tag, "_ivalid"}, instruction_valid, 0);
        chk({tag, "_pvalid"}, peek_valid, 0);
        chk({tag, "_instr"}, instruction, 0);
        chk({tag, "_peek"}, peek, 0);
        chk({tag, "_read"}, p_ram_read, 0);
        chk({tag, "_haddr"}, head_address, 0);
        chk({tag, "_paddr"}, p_ram_address, 0);
        chk({tag, "_uflow"}, underflow_error, 0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; flush = 1'b0; flush_address = 16'h0; consume = 2'd0;
        repeat (2) @(negedge clock);
        chk_reset("reset");

        // Fill from address 0 with no consumption.
        reset_n = 1'b1; enable = 1'b1; load_stream(16'h0000);
        #1 chk("no_read_before_edge", p_ram_read, 0);
        rd_seen = 0;
        for (int i = 0; i < 12 && occupancy != 3'd4; i++) begin
            @(negedge clock);
            if (p_ram_read) begin
                chk("fill_read_addr", p_ram_address, 32'(rd_seen));
                rd_seen++;
            end
        end
        repeat (3) begin
            @(negedge clock);
            if (p_ram_read) rd_seen++;
        end
        chk("fill_read_count", rd_seen, 4);
        chk("fill_occ", occupancy, 4);
        chk("fill_instr", instruction, 16'h1100);
        chk("fill_peek", peek, 16'h2205);
        chk("fill_pvalid", peek_valid, 1);

        // Pop two words at once.
        consume = 2'd2; void'(exp_q.pop_front()); void'(exp_q.pop_front());
        @(negedge clock); consume = 2'd0;
        chk_head("pop2");
        chk("pop2_instr_lit", instruction, 16'h3300);
        chk("pop2_peek", peek, 16'h4400);
        chk("pop2_occ", occupancy, 2);
        chk("pop2_read", p_ram_read, 1);
        chk("pop2_paddr", p_ram_address, 16'h0004);
        @(negedge clock);
        chk("pop2_read2", p_ram_read, 1);
        chk("pop2_paddr2", p_ram_address, 16'h0005);
        for (int i = 0; i < 10 && occupancy != 3'd4; i++) @(negedge clock);

        // Steady 1 word/cycle consumption.
        for (int i = 0; i < 10; i++) begin
            chk("stream_valid", instruction_valid, 1);
            chk_head("stream");
            consume = 2'd1; void'(exp_q.pop_front());
            @(negedge clock);
        end
        consume = 2'd0;

        // Flush with a read in flight.
        chk("pre_flush_read", p_ram_read, 1);
        flush = 1'b1; flush_address = 16'h0010;
        @(negedge clock);
        chk("flush_occ", occupancy, 0);
        chk("flush_paddr", p_ram_address, 16'h0010);
        chk("flush_ivalid", instruction_valid, 0);
        flush = 1'b0; load_stream(16'h0010);
        #1 chk("redirect_read", p_ram_read, 1);
        @(negedge clock);
        chk("stale_dropped_occ", occupancy, 0);
        @(negedge clock);
        chk("redirect_occ", occupancy, 1);
        chk_head("redirect");

        // Over-consume: no pop, sticky flag.
        consume = 2'd2;
        @(negedge clock); consume = 2'd0;
        chk("uflow_set", underflow_error, 1);
        chk("uflow_occ", occupancy, 2);
        chk_head("uflow");

        // Address wrap at top of memory.
        flush = 1'b1; flush_address = 16'hFFFF;
        @(negedge clock); flush = 1'b0; load_stream(16'hFFFF);
        #1 chk("wrap_read", p_ram_read, 1);
        chk("wrap_paddr0", p_ram_address, 16'hFFFF);
        @(negedge clock);
        chk("wrap_paddr1", p_ram_address, 16'h0000);
        for (int i = 0; i < 10 && occupancy < 3'd2; i++) @(negedge clock);
        chk_head("wrap");
        chk("wrap_peek", peek, exp_q[1].data);
        consume = 2'd1; void'(exp_q.pop_front());
        @(negedge clock); consume = 2'd0;
        chk_head("wrap_pop");
        chk("uflow_sticky", underflow_error, 1);

        // Enable drops with a word in flight.
        flush = 1'b1; flush_address = 16'h0020;
        @(negedge clock); flush = 1'b0; load_stream(16'h0020);
        @(negedge clock);
        enable = 1'b0;
        #1 chk("halt_no_read", p_ram_read, 0);
        @(negedge clock);
        chk("halt_occ", occupancy, 1);
        chk_head("halt");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("halt_idle_read", p_ram_read, 0);
            chk("halt_stable_occ", occupancy, 1);
        end

        // Reset pulsed with a read in flight.
        enable = 1'b1;
        @(negedge clock);
        chk("resume_read", p_ram_read, 1);
        chk("resume_paddr", p_ram_address, 16'h0021);
        @(negedge clock);
        reset_n = 1'b0;
        #1 chk_reset("midreset");
        enable = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_occ", occupancy, 0);
        chk("post_reset_ivalid", instruction_valid, 0);
        chk("post_reset_uflow", underflow_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
